// File: rtl/chord_seq_pkg.sv
// chord_seq_pkg: shared state encoding, song word layout and end marker for the chord sequencer
package chord_seq_pkg;
  localparam int WAIT_BIT = 15;
  localparam int NOTE_MSB = 14;
  localparam int NOTE_LSB = 9;
  localparam int DUR_MSB = 8;
  localparam int DUR_LSB = 3;
  localparam logic [15:0] END_WORD = 16'h0000;
  typedef enum logic [3:0] {
    IDLE, FETCH, DECODE, ISSUE_NOTE, ISSUE_WAIT, LOAD, SETTLE, WAIT_HOLD, DONE
  } state_t;
  typedef struct packed {
    logic is_wait;
    logic [5:0] note;
    logic [5:0] dur;
  } word_t;
endpackage

// File: rtl/chord_sequencer_decode.sv
// seq_word_decode: splits a song ROM word into end/wait/skip flags and note/duration fields
module seq_word_decode
  import chord_seq_pkg::*;
(
  input  logic [15:0] word,
  output logic        is_end,
  output logic        is_wait,
  output logic        skip,
  output logic [5:0]  note,
  output logic [5:0]  duration
);
  assign is_end = word == END_WORD;
  assign is_wait = word[WAIT_BIT];
  assign note = word[NOTE_MSB:NOTE_LSB];
  assign duration = word[DUR_MSB:DUR_LSB];
  assign skip = is_wait && duration == 6'd0;
endmodule

// File: rtl/chord_sequencer.sv
// chord_sequencer: walks a song ROM and issues note/wait loads to the chord player; CHORD_SEQ_LOOP_EN makes songs repeat
module chord_sequencer
  import chord_seq_pkg::*;
#(
  parameter int ADDR_WIDTH = 7,
  parameter int SONG_BITS = 2
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            play_enable,
  input  logic                            new_song,
  input  logic [SONG_BITS-1:0]            song_sel,
  output logic [SONG_BITS+ADDR_WIDTH-1:0] rom_addr,
  input  logic [15:0]                     rom_data,
  input  logic                            slot_free,
  input  logic                            done_waiting,
  output logic [5:0]                      note_to_load,
  output logic [5:0]                      duration,
  output logic                            load_new_note,
  output logic                            waiting,
  output logic                            song_playing,
  output logic                            song_done
);
  state_t state;
  logic [ADDR_WIDTH-1:0] word_idx;
  logic [SONG_BITS-1:0] song_sel_q;
  word_t word_q;
  logic d_end, d_wait, d_skip;
  logic [5:0] d_note, d_dur;
  logic adv, fin;
  seq_word_decode u_dec (
    .word(rom_data),
    .is_end(d_end),
    .is_wait(d_wait),
    .skip(d_skip),
    .note(d_note),
    .duration(d_dur)
  );
  // A word is finished when skipped, after a note settles, or when its wait expires; the last index or end marker ends the pass
  always_comb begin
    adv = (state == DECODE && d_skip) || (state == SETTLE && !word_q.is_wait) ||
          (state == WAIT_HOLD && play_enable && done_waiting);
    fin = (state == DECODE && d_end) || (adv && &word_idx);
  end
  // Sequencer FSM: new_song wins over everything, then end-of-pass, then advance, then per-state moves
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state <= IDLE;
      word_idx <= '0;
      song_sel_q <= '0;
      word_q <= '0;
      song_done <= 1'b0;
    end else begin
      song_done <= 1'b0;
      if (state == DECODE) word_q <= '{is_wait: d_wait, note: d_note, dur: d_dur};
      if (new_song) begin
        state <= FETCH;
        word_idx <= '0;
        song_sel_q <= song_sel;
      end else if (fin) begin
        song_done <= 1'b1;
`ifdef CHORD_SEQ_LOOP_EN
        state <= FETCH;
        word_idx <= '0;
`else
        state <= DONE;
`endif
      end else if (adv) begin
        state <= FETCH;
        word_idx <= word_idx + 1'b1;
      end else
        case (state)
          FETCH:      state <= DECODE;
          DECODE:     state <= d_wait ? ISSUE_WAIT : ISSUE_NOTE;
          ISSUE_NOTE: if (play_enable && slot_free) state <= LOAD;
          ISSUE_WAIT: if (play_enable && done_waiting) state <= LOAD;
          LOAD:       state <= SETTLE;
          SETTLE:     state <= WAIT_HOLD;
          default:    ;
        endcase
    end
  assign rom_addr = {song_sel_q, word_idx};
  assign load_new_note = state == LOAD;
  assign waiting = word_q.is_wait && (state inside {ISSUE_WAIT, LOAD, SETTLE, WAIT_HOLD});
  assign note_to_load = word_q.note;
  assign duration = word_q.dur;
  assign song_playing = !(state == IDLE || state == DONE);
endmodule

// File: tb/tb_chord_sequencer.sv
// tb_chord_sequencer: table, directed and randomized checks of chord_sequencer against a song-walk model
module tb_chord_sequencer;
  localparam int AW = 7;
  localparam int SB = 2;
`ifdef CHORD_SEQ_LOOP_EN
  localparam logic LOOP = 1'b1;
`else
  localparam logic LOOP = 1'b0;
`endif
  typedef struct {
    logic [5:0] note;
    logic [5:0] dur;
    logic       wt;
    logic [8:0] addr;
  } ld_t;
  typedef struct {
    logic [15:0] word;
    logic        exp_load;
    logic [5:0]  exp_note;
    logic [5:0]  exp_dur;
    logic        exp_wait;
  } vec_t;

  logic clk = 0, reset = 0, play_enable = 0, new_song = 0, slot_free = 0, done_waiting = 0;
  logic [SB-1:0] song_sel = '0;
  logic [SB+AW-1:0] rom_addr;
  logic [15:0] rom_data;
  logic [5:0] note_to_load, duration;
  logic load_new_note, waiting, song_playing, song_done;
  logic [15:0] rom [0:511];
  ld_t cap[$];
  ld_t exp_q[$];
  int checks = 0, errors = 0, done_cnt = 0;
  logic prev_pe = 0, prev_sf = 0, prev_dw = 0;

  chord_sequencer #(.ADDR_WIDTH(AW), .SONG_BITS(SB)) dut (
    .clk(clk), .reset(reset), .play_enable(play_enable), .new_song(new_song),
    .song_sel(song_sel), .rom_addr(rom_addr), .rom_data(rom_data),
    .slot_free(slot_free), .done_waiting(done_waiting),
    .note_to_load(note_to_load), .duration(duration), .load_new_note(load_new_note),
    .waiting(waiting), .song_playing(song_playing), .song_done(song_done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) rom_data <= rom[rom_addr];

  always @(negedge clk) begin
    if (reset && load_new_note) begin
      checks++;
      if (!(prev_pe && (waiting ? prev_dw : prev_sf))) begin
        errors++;
        $display("FAIL load_ready: load at addr %0h got pe=%0b sf=%0b dw=%0b, required ready condition", rom_addr, prev_pe, prev_sf, prev_dw);
      end
      cap.push_back('{note_to_load, duration, waiting, rom_addr});
    end
    if (reset && song_done) done_cnt++;
    prev_pe = play_enable;
    prev_sf = slot_free;
    prev_dw = done_waiting;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_ld(input string nm, input ld_t a, input ld_t e);
    chk(nm, {10'd0, a.note, a.dur, a.wt, a.addr}, {10'd0, e.note, e.dur, e.wt, e.addr});
  endtask

  task automatic clear_song(input int s);
    for (int i = 0; i < 128; i++) rom[s*128+i] = 16'h0000;
  endtask

  task automatic start(input int s);
    song_sel = SB'(s);
    new_song = 1;
    step();
    new_song = 0;
  endtask

  task automatic wait_loads(input int n, input int budget, input string nm);
    for (int i = 0; i < budget && cap.size() < n; i++) step();
    chk(nm, cap.size(), n);
  endtask

  task automatic wait_done(input int d0, input int budget, input string nm);
    for (int i = 0; i < budget && done_cnt <= d0; i++) step();
    chk(nm, done_cnt > d0, 1);
  endtask

  vec_t tbl[7];
  int d0, s, len;
  logic [15:0] w;

  initial begin
    tbl[0] = '{16'h2840, 1'b1, 6'd20, 6'd8, 1'b0};
    tbl[1] = '{16'h0208, 1'b1, 6'd1, 6'd1, 1'b0};
    tbl[2] = '{16'h01F8, 1'b1, 6'd0, 6'd63, 1'b0};
    tbl[3] = '{16'h7FFF, 1'b1, 6'd63, 6'd63, 1'b0};
    tbl[4] = '{16'h8020, 1'b1, 6'd0, 6'd4, 1'b1};
    tbl[5] = '{16'h8007, 1'b0, 6'd0, 6'd0, 1'b0};
    tbl[6] = '{16'h0000, 1'b0, 6'd0, 6'd0, 1'b0};
    for (int i = 0; i < 512; i++) rom[i] = 16'h0000;

    step();
    step();
    chk("rst_rom_addr", rom_addr, 0);
    chk("rst_load", load_new_note, 0);
    chk("rst_waiting", waiting, 0);
    chk("rst_note", note_to_load, 0);
    chk("rst_dur", duration, 0);
    chk("rst_playing", song_playing, 0);
    chk("rst_done", song_done, 0);
    reset = 1;

    rom[0] = 16'h2840;
    rom[1] = 16'h0000;
    play_enable = 1; slot_free = 1; done_waiting = 0;
    start(0);
    step(); step(); step();
    chk("midload_pre", load_new_note, 1);
    reset = 0;
    #1;
    chk("midload_rst_load", load_new_note, 0);
    chk("midload_rst_playing", song_playing, 0);
    chk("midload_rst_note", note_to_load, 0);
    step();
    reset = 1;

    cap.delete();
    d0 = done_cnt;
    start(0);
    chk("basic_playing", song_playing, 1);
    chk("basic_addr", rom_addr, 0);
    step(); step();
    chk("basic_c3_noload", load_new_note, 0);
    step();
    chk("basic_c4_load", load_new_note, 1);
    chk("basic_note", note_to_load, 20);
    chk("basic_dur", duration, 8);
    chk("basic_waiting", waiting, 0);
    wait_done(d0, 20, "basic_done");
    step(); step(); step();
    chk("basic_done_once", done_cnt - d0, 1);
    chk("basic_playing_end", song_playing, LOOP);

    clear_song(2);
    for (int t = 0; t < 7; t++) begin
      rom[256] = tbl[t].word;
      play_enable = 1; slot_free = 1; done_waiting = 1;
      cap.delete();
      d0 = done_cnt;
      start(2);
      step(); step(); step();
      chk($sformatf("tbl%0d_load", t), load_new_note, tbl[t].exp_load);
      if (tbl[t].exp_load) begin
        chk($sformatf("tbl%0d_note", t), note_to_load, tbl[t].exp_note);
        chk($sformatf("tbl%0d_dur", t), duration, tbl[t].exp_dur);
        chk($sformatf("tbl%0d_wait", t), waiting, tbl[t].exp_wait);
      end
      wait_done(d0, 20, $sformatf("tbl%0d_done", t));
      chk($sformatf("tbl%0d_nloads", t), cap.size(), tbl[t].exp_load);
      chk($sformatf("tbl%0d_playing", t), song_playing, LOOP);
    end

    clear_song(1);
    rom[128] = 16'h2840; rom[129] = 16'h2A40; rom[130] = 16'h8020; rom[131] = 16'h2840;
    play_enable = 1; slot_free = 1; done_waiting = 0;
    cap.delete();
    start(1);
    wait_loads(2, 40, "chord_two_loads");
    repeat (30) step();
    chk("chord_wait_blocked", cap.size(), 2);
    chk("chord_waiting_high", waiting, 1);
    done_waiting = 1;
    step();
    chk("chord_wait_load", load_new_note, 1);
    chk("chord_wait_flag", waiting, 1);
    chk("chord_wait_dur", duration, 4);
    done_waiting = 0;
    repeat (50) step();
    chk("chord_hold_blocked", cap.size(), 3);
    done_waiting = 1;
    wait_loads(4, 20, "chord_fourth_load");
    done_waiting = 0;
    if (cap.size() == 4) begin
      chk_ld("chord_ld0", cap[0], '{6'd20, 6'd8, 1'b0, 9'd128});
      chk_ld("chord_ld1", cap[1], '{6'd21, 6'd8, 1'b0, 9'd129});
      chk_ld("chord_ld2", cap[2], '{6'd0, 6'd4, 1'b1, 9'd130});
      chk_ld("chord_ld3", cap[3], '{6'd20, 6'd8, 1'b0, 9'd131});
    end

    play_enable = 1; slot_free = 0;
    cap.delete();
    start(0);
    step(); step();
    repeat (20) step();
    chk("noslot_blocked", cap.size(), 0);
    chk("noslot_no_strobe", load_new_note, 0);
    slot_free = 1;
    step();
    chk("noslot_load", load_new_note, 1);
    step();
    chk("noslot_single", load_new_note, 0);

    clear_song(1);
    rom[128] = 16'h2840; rom[129] = 16'h2A40;
    play_enable = 0; slot_free = 1;
    cap.delete();
    start(1);
    repeat (15) step();
    chk("pause_blocked", cap.size(), 0);
    chk("pause_addr_hold", rom_addr, 128);
    play_enable = 1;
    wait_loads(1, 5, "pause_resume1");
    play_enable = 0;
    repeat (10) step();
    chk("pause_blocked2", cap.size(), 1);
    play_enable = 1;
    wait_loads(2, 10, "pause_resume2");
    repeat (10) step();
    chk("pause_no_dup", cap.size(), 2);
    if (cap.size() == 2) begin
      chk("pause_addr0", cap[0].addr, 128);
      chk("pause_addr1", cap[1].addr, 129);
    end

    clear_song(0);
    rom[0] = 16'h8020; rom[1] = 16'h2840;
    clear_song(2);
    rom[256] = 16'h8000; rom[257] = 16'h2A40;
    play_enable = 1; slot_free = 1; done_waiting = 1;
    cap.delete();
    start(0);
    wait_loads(1, 10, "restart_wait_load");
    done_waiting = 0;
    repeat (5) step();
    chk("restart_held", cap.size(), 1);
    song_sel = 2'd2;
    new_song = 1;
    step();
    new_song = 0;
    chk("restart_addr", rom_addr, 256);
    chk("restart_playing", song_playing, 1);
    chk("restart_noload", load_new_note, 0);
    wait_loads(2, 20, "restart_next_load");
    if (cap.size() == 2) begin
      chk_ld("restart_ld0", cap[0], '{6'd0, 6'd4, 1'b1, 9'd0});
      chk_ld("restart_ld1", cap[1], '{6'd21, 6'd8, 1'b0, 9'd257});
    end

    for (int i = 0; i < 128; i++) rom[384+i] = 16'h2840;
    play_enable = 1; slot_free = 1; done_waiting = 0;
    cap.delete();
    d0 = done_cnt;
    start(3);
    wait_done(d0, 128*6+20, "wrap_done");
    chk("wrap_nloads", cap.size(), 128);
    if (cap.size() == 128) chk("wrap_last_addr", cap[127].addr, 511);
    step(); step();
    chk("wrap_playing", song_playing, LOOP);
`ifdef CHORD_SEQ_LOOP_EN
    wait_loads(129, 10, "loop_reload");
    if (cap.size() >= 129) chk("loop_addr0", cap[128].addr, 384);
    wait_done(d0 + 1, 128*6+20, "loop_second_done");
    chk("loop_done_count", done_cnt - d0, 2);
`else
    repeat (20) step();
    chk("wrap_stopped", cap.size(), 128);
    chk("wrap_done_once", done_cnt - d0, 1);
`endif

    for (int it = 0; it < 4; it++) begin
      s = $urandom_range(0, 3);
      len = $urandom_range(3, 30);
      clear_song(s);
      for (int i = 0; i < len; i++) begin
        case ($urandom % 4)
          0: w = {1'b1, 6'($urandom), 6'($urandom_range(1, 7)), 3'($urandom)};
          1: w = {1'b1, 6'($urandom), 6'd0, 3'($urandom)};
          default: w = {1'b0, 6'($urandom), 6'($urandom_range(1, 63)), 3'($urandom)};
        endcase
        rom[s*128+i] = w;
      end
      exp_q.delete();
      for (int i = 0; i < 128; i++) begin
        w = rom[s*128+i];
        if (w == 16'h0000) break;
        if (w[15] && w[8:3] == 6'd0) continue;
        exp_q.push_back('{w[14:9], w[8:3], w[15], 9'(s*128+i)});
      end
      cap.delete();
      d0 = done_cnt;
      play_enable = 1; slot_free = 1; done_waiting = 0;
      start(s);
      for (int c = 0; c < 4000 && done_cnt <= d0; c++) begin
        play_enable = ($urandom % 4) != 0;
        slot_free = $urandom % 2;
        done_waiting = $urandom % 2;
        step();
      end
      chk($sformatf("rand%0d_done", it), done_cnt > d0, 1);
      chk($sformatf("rand%0d_nloads", it), cap.size(), exp_q.size());
      for (int i = 0; i < exp_q.size() && i < cap.size(); i++)
        chk_ld($sformatf("rand%0d_ld%0d", it, i), cap[i], exp_q[i]);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/chord_sequencer.md
Name: chord_sequencer

Overview:
Note-stream initiator that drives the chord playback engine's note-load interface.
- Walks a song ROM word by word and issues note loads into free chord slots.
- Issues wait loads into the waiter slot and holds off later words until the wait expires.
- Sits between the song ROM and the chord player. It produces note_to_load, duration, load_new_note and waiting, and consumes the slot-free and done_waiting status.

Parameters:
ADDR_WIDTH, 7, word index bits per song (128 words per song)
SONG_BITS, 2, song select bits; rom_addr = {song_sel_q, word_idx}

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
play_enable  in  1  level; 0 freezes issuing (FSM holds state)
new_song  in  1  pulse; (re)start song song_sel at word 0
song_sel  in  SONG_BITS  song to start, sampled on new_song
rom_addr  out  SONG_BITS+ADDR_WIDTH  song ROM address (1-cycle synchronous read)
rom_data  in  16  ROM word: [15] is_wait, [14:9] note, [8:3] duration, [2:0] ignored
slot_free  in  1  OR of the three note-slot done flags (waiter slot excluded)
done_waiting  in  1  waiter slot done flag
note_to_load  out  6  note field of current word
duration  out  6  duration field of current word
load_new_note  out  1  one-cycle load strobe
waiting  out  1  high while current word is a wait
song_playing  out  1  high from new_song until DONE
song_done  out  1  one-cycle pulse on reaching end of song

Behaviour:
- Reset: state IDLE, word_idx=0, song_sel_q=0, word register=0. All outputs 0.
- States: IDLE, FETCH, DECODE, ISSUE_NOTE, ISSUE_WAIT, LOAD, SETTLE, WAIT_HOLD, DONE.
- All outputs are decoded from registered state and registers only; no combinational path from inputs.
- new_song, accepted in any state:
  - next cycle the FSM is in FETCH, word_idx=0, song_sel_q=song_sel;
  - overrides every other transition;
  - notes already loaded keep sounding, with no flush.
- FETCH: rom_addr stable. Go to DECODE.
- DECODE: latch rom_data into the word register. Then:
  - word==16'h0000 -> DONE;
  - is_wait with duration 0 -> advance;
  - is_wait -> ISSUE_WAIT;
  - otherwise -> ISSUE_NOTE. A note value of 0 with nonzero duration is a rest and is issued normally.
- ISSUE_NOTE: when play_enable && slot_free -> LOAD; otherwise stay.
- ISSUE_WAIT: waiting=1. When play_enable && done_waiting -> LOAD; otherwise stay.
- LOAD:
  - load_new_note=1 for exactly this cycle;
  - waiting stays 1 for a wait word;
  - note_to_load/duration = word fields;
  - go to SETTLE.
- SETTLE: one cycle so the slot done flags reflect the load. Then:
  - wait word -> WAIT_HOLD;
  - note word -> advance.
- WAIT_HOLD: stay until done_waiting=1, then advance. Notes after a wait never issue before the wait expires.
- Advance: word_idx+1 -> FETCH. If word_idx was all-ones (wrap) -> DONE instead.
- DONE: song_done=1 on the entry cycle only; song_playing=0; stay until new_song.
- Latency: new_song at cycle 0 -> FETCH 1 -> DECODE 2 -> ISSUE 3 -> load_new_note at cycle 4 if the ready condition holds at cycle 3. Minimum spacing between loads is 5 cycles.
- play_enable=0: only ISSUE_NOTE, ISSUE_WAIT and WAIT_HOLD stall. FETCH/DECODE/LOAD/SETTLE complete. No load is ever issued while play_enable=0 was sampled.
- Reset asserted mid-operation: immediate return to reset values, including any in-flight LOAD.

Optional Feature:
CHORD_SEQ_LOOP_EN
- Defined: end marker or index wrap reloads word_idx=0 and goes to FETCH. song_done still pulses once per pass; song_playing stays 1.
- Undefined: DONE behaviour as above.

Decomposition:
- Package chord_seq_pkg:
  - state enum;
  - field bit positions (WAIT_BIT=15, NOTE_MSB/LSB=14/9, DUR_MSB/LSB=8/3);
  - END_WORD=16'h0000;
  - word struct/typedef.
- One natural sub-module: seq_word_decode, a combinational word -> {is_end, is_wait, skip, note, duration}.

Test Plan:
- Basic note: ROM song0 {16'h2840, 16'h0000}, slot_free=1, new_song at cycle 0 -> load_new_note=1 at cycle 4 with note_to_load=20, duration=8, waiting=0; later song_done pulses once, song_playing=0.
- Chord then wait: {16'h2840, 16'h2A40, 16'h8020, 16'h2840} -> two note loads. Then waiting=1, and the load with duration=4 occurs only when done_waiting=1. Hold done_waiting=0 for 50 cycles after -> the fourth note is not loaded until done_waiting returns to 1.
- No free slot: slot_free=0 for 20 cycles during ISSUE_NOTE -> no load. Raise slot_free -> exactly one load one cycle later.
- Pause: play_enable=0 while in ISSUE_NOTE -> no load. Re-enable -> load resumes, with no duplicate or skipped word (check rom_addr sequence).
- Restart: new_song with song_sel=2 mid-WAIT_HOLD -> next cycle rom_addr=2<<7, FETCH. A wait word with duration 0 is skipped with no load.
- Wrap/loop: fill 128 non-end words -> DONE after index 127. With CHORD_SEQ_LOOP_EN -> rom_addr returns to word 0 and song_done pulses each pass.
